// File: rtl/posit_arb_pkg.sv
// Shared defaults and types for the two-requester posit adder arbiter.
`default_nettype none

package posit_arb_pkg;
  localparam int N       = 32;
  localparam int ES      = 3;
  localparam int LATENCY = 4;

  typedef logic req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

  // Response word layout; the FIFOs carry exactly these N+2 bits.
  typedef struct packed {
    logic [N-1:0] result;
    logic         inf;
    logic         zero;
  } rsp_t;
endpackage

`default_nettype wire

// File: rtl/posit_rsp_fifo.sv
// Synchronous response FIFO; head word is presented combinationally.
`default_nettype none

module posit_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  // Upstream credits bound occupancy, so a push can never meet a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

`default_nettype wire

// File: rtl/posit_add_arbiter.sv
// Round-robin sharing of one fixed-latency posit adder between two requesters,
// with credit-gated issue, an in-flight tag pipe and per-requester response FIFOs.
`default_nettype none

module posit_add_arbiter #(
  parameter int N          = posit_arb_pkg::N,
  parameter int ES         = posit_arb_pkg::ES,
  parameter int LATENCY    = posit_arb_pkg::LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in1,
  input  logic [N-1:0] req0_in2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in1,
  input  logic [N-1:0] req1_in2,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_result,
  output logic         rsp0_inf,
  output logic         rsp0_zero,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_result,
  output logic         rsp1_inf,
  output logic         rsp1_zero,
  output logic [N-1:0] add_in1,
  output logic [N-1:0] add_in2,
  output logic         add_start,
  input  logic [N-1:0] add_result,
  input  logic         add_inf,
  input  logic         add_zero,
  input  logic         add_done,
  output logic         err
);
  import posit_arb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int MW = $clog2(LATENCY + 2);
  localparam logic [MW-1:0] MASK_DONE = MW'(LATENCY + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LATENCY < 1 || ES < 0)
  begin : g_bad_params
    $error("posit_add_arbiter: illegal parameter set");
  end

  logic          elig0, elig1, grant0, grant1, issue;
  logic          prio;  // 0: req0 wins a tie, 1: req1 wins a tie
  logic [CW-1:0] credit0, credit1;
  logic          pop0, pop1, push0, push1, empty0, empty1;
  logic [N+1:0]  rsp_word, head0, head1;
  logic [MW-1:0] mask_cnt;
  tag_t          tag_q [LATENCY+1];
  tag_t          exit_tag;

  assign elig0 = req0_valid && (credit0 != '0);
  assign elig1 = req1_valid && (credit1 != '0);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && (!elig1 || !prio))
      grant0 = 1'b1;
    else if (elig1)
      grant1 = 1'b1;
  end

  assign issue      = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      add_start <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
    end else begin
      add_start <= issue;
      if (issue) begin
        prio    <= grant0;
        add_in1 <= grant1 ? req1_in1 : req0_in1;
        add_in2 <= grant1 ? req1_in2 : req0_in2;
      end
    end
  end

  // Stage 0 lines up with add_start, stage LATENCY with add_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{v: issue, id: grant1};
      for (int i = 1; i <= LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign exit_tag = tag_q[LATENCY];
  assign push0    = exit_tag.v && (exit_tag.id == 1'b0);
  assign push1    = exit_tag.v && (exit_tag.id == 1'b1);
  assign pop0     = rsp0_valid && rsp0_ready;
  assign pop1     = rsp1_valid && rsp1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit0 <= CW'(FIFO_DEPTH);
      credit1 <= CW'(FIFO_DEPTH);
    end else begin
      if (grant0 && !pop0)
        credit0 <= credit0 - CW'(1);
      else if (!grant0 && pop0)
        credit0 <= credit0 + CW'(1);
      if (grant1 && !pop1)
        credit1 <= credit1 - CW'(1);
      else if (!grant1 && pop1)
        credit1 <= credit1 + CW'(1);
    end
  end

  // The adder pipeline is not reset, so its done flag is untrusted until it has flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (mask_cnt != MASK_DONE)
        mask_cnt <= mask_cnt + MW'(1);
      else if (exit_tag.v != add_done)
        err <= 1'b1;
    end
  end

  assign rsp_word = {add_result, add_inf, add_zero};

  posit_rsp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(N + 2)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .din(rsp_word),
    .pop(pop0), .dout(head0), .empty(empty0)
  );

  posit_rsp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(N + 2)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .din(rsp_word),
    .pop(pop1), .dout(head1), .empty(empty1)
  );

  assign rsp0_valid  = !empty0;
  assign rsp0_result = head0[N+1:2];
  assign rsp0_inf    = head0[1];
  assign rsp0_zero   = head0[0];
  assign rsp1_valid  = !empty1;
  assign rsp1_result = head1[N+1:2];
  assign rsp1_inf    = head1[1];
  assign rsp1_zero   = head1[0];
endmodule

`default_nettype wire
